// File: rtl/sdram_frame_pack.sv
// sdram_frame_pack
//
// Write-side framer for the SDRAM path. Each start request moves frame_length words from the
// capture (source) FIFO into the SDRAM write (destination) FIFO, then appends PAD_WORD fill
// words until sdram_length words have been written. Every frame lands in SDRAM as a
// fixed-size block of max(frame_length, sdram_length) words.
//
// Ports:
//   clk            system clock
//   nRST           synchronous active-low reset
//   sdram_wr       start request, asynchronous level, rising edge starts a job
//   frame_length   payload words per frame, sampled at job start
//   sdram_length   total words per SDRAM block, sampled at job start
//   fifo_num_src   source FIFO fill count
//   src_data       source FIFO read data, valid the cycle after fifo_rden
//   fifo_dst_ready destination FIFO has room for at least 4 words
//   fifo_rden      source FIFO read enable
//   fifo_wren      destination FIFO write enable
//   fifo_wdata     destination FIFO write data (don't-care while fifo_wren is low)
//   busy           job in progress
//   pack_done      one-cycle pulse at job end
module sdram_frame_pack #(
    parameter int unsigned       DATA_W     = 32,
    parameter logic [DATA_W-1:0] PAD_WORD   = '0,
    parameter logic [14:0]       SRC_THRESH = 15'd10
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              sdram_wr,
    input  logic [31:0]       frame_length,
    input  logic [31:0]       sdram_length,
    input  logic [14:0]       fifo_num_src,
    input  logic [DATA_W-1:0] src_data,
    input  logic              fifo_dst_ready,
    output logic              fifo_rden,
    output logic              fifo_wren,
    output logic [DATA_W-1:0] fifo_wdata,
    output logic              busy,
    output logic              pack_done
);

    typedef enum logic [1:0] {
        StIdle,
        StFrame,
        StPad,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Input conditioning
    logic wr0_q, wr1_q, wr2_q;
    logic start_q;
    logic src_ok_q, dst_ok_q;

    // Job parameters latched at start
    logic [31:0] flen_q, flen_d;
    logic [31:0] slen_q, slen_d;
    logic [31:0] total_q, total_d;  // max(flen, slen): words written by this job
    logic [31:0] count_q, count_d;

    // Issue stage
    logic rden_q, rden_d;
    logic pad_req_q, pad_req_d;
    logic last_iss_q, last_iss_d;  // the word issued this cycle is the job's final word

    // Write stage
    logic wren_q;
    logic sel_pad_q;
    logic last_wr_q;

    logic pack_done_q, pack_done_d;
    logic zero_done;
    logic [31:0] count_inc;

    assign count_inc = count_q + 32'd1;

    always_comb begin
        state_d    = state_q;
        flen_d     = flen_q;
        slen_d     = slen_q;
        total_d    = total_q;
        count_d    = count_q;
        rden_d     = 1'b0;
        pad_req_d  = 1'b0;
        last_iss_d = 1'b0;
        zero_done  = 1'b0;

        unique case (state_q)
            StIdle: begin
                count_d = '0;
                if (start_q) begin
                    flen_d  = frame_length;
                    slen_d  = sdram_length;
                    total_d = (frame_length >= sdram_length) ? frame_length : sdram_length;
                    state_d = (frame_length == 32'd0) ? StPad : StFrame;
                end
            end

            StFrame: begin
                if (count_q == flen_q) begin
                    state_d = StPad;
                end else if (src_ok_q && dst_ok_q && (count_q < flen_q)) begin
                    rden_d     = 1'b1;
                    count_d    = count_inc;
                    last_iss_d = (count_inc == total_q);
                end
            end

            StPad: begin
                // With flen >= slen the count already meets slen, so nothing is padded.
                if (count_q >= slen_q) begin
                    state_d   = StDone;
                    // A zero-word job has no final write to trail, so report it here.
                    zero_done = (total_q == 32'd0);
                end else if (dst_ok_q) begin
                    pad_req_d  = 1'b1;
                    count_d    = count_inc;
                    last_iss_d = (count_inc == total_q);
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Completion follows the final write by one cycle.
    assign pack_done_d = last_wr_q | zero_done;

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q     <= StIdle;
            wr0_q       <= 1'b0;
            wr1_q       <= 1'b0;
            wr2_q       <= 1'b0;
            start_q     <= 1'b0;
            src_ok_q    <= 1'b0;
            dst_ok_q    <= 1'b0;
            flen_q      <= '0;
            slen_q      <= '0;
            total_q     <= '0;
            count_q     <= '0;
            rden_q      <= 1'b0;
            pad_req_q   <= 1'b0;
            last_iss_q  <= 1'b0;
            wren_q      <= 1'b0;
            sel_pad_q   <= 1'b0;
            last_wr_q   <= 1'b0;
            pack_done_q <= 1'b0;
        end else begin
            // Two flops resynchronise the async request, the third detects its rising edge.
            wr0_q       <= sdram_wr;
            wr1_q       <= wr0_q;
            wr2_q       <= wr1_q;
            start_q     <= wr1_q & ~wr2_q;
            src_ok_q    <= (fifo_num_src > SRC_THRESH);
            dst_ok_q    <= fifo_dst_ready;
            state_q     <= state_d;
            flen_q      <= flen_d;
            slen_q      <= slen_d;
            total_q     <= total_d;
            count_q     <= count_d;
            rden_q      <= rden_d;
            pad_req_q   <= pad_req_d;
            last_iss_q  <= last_iss_d;
            wren_q      <= rden_q | pad_req_q;
            sel_pad_q   <= pad_req_q;
            last_wr_q   <= last_iss_q;
            pack_done_q <= pack_done_d;
        end
    end

    assign fifo_rden  = rden_q;
    assign fifo_wren  = wren_q;
    // Source data arrives the cycle after the read, aligned with the registered select.
    assign fifo_wdata = sel_pad_q ? PAD_WORD : src_data;
    assign busy       = (state_q != StIdle);
    assign pack_done  = pack_done_q;

endmodule

// File: tb/tb_sdram_frame_pack.sv
// Testbench for sdram_frame_pack: a source FIFO model feeds the DUT, and a job-level model
// predicts the exact destination write stream (flen source words, then pad words up to slen),
// the read count and a single completion pulse per job.
module tb_sdram_frame_pack;

    localparam logic [31:0] PAD = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        nRST;
    logic        sdram_wr;
    logic [31:0] frame_length;
    logic [31:0] sdram_length;
    logic [14:0] fifo_num_src;
    logic [31:0] src_data;
    logic        fifo_dst_ready;
    logic        fifo_rden;
    logic        fifo_wren;
    logic [31:0] fifo_wdata;
    logic        busy;
    logic        pack_done;

    sdram_frame_pack #(
        .DATA_W    (32),
        .PAD_WORD  (PAD),
        .SRC_THRESH(15'd10)
    ) dut (
        .clk           (clk),
        .nRST          (nRST),
        .sdram_wr      (sdram_wr),
        .frame_length  (frame_length),
        .sdram_length  (sdram_length),
        .fifo_num_src  (fifo_num_src),
        .src_data      (src_data),
        .fifo_dst_ready(fifo_dst_ready),
        .fifo_rden     (fifo_rden),
        .fifo_wren     (fifo_wren),
        .fifo_wdata    (fifo_wdata),
        .busy          (busy),
        .pack_done     (pack_done)
    );

    always #5 clk = ~clk;

    // Source FIFO storage: main process fills, source process drains.
    logic [31:0] src_mem [256];
    logic [31:0] wr_ptr = 0;
    logic [31:0] rd_ptr;
    int          uflow;

    // Source FIFO model: pops on the edge where fifo_rden is high, data valid after that edge.
    initial begin
        logic rd;
        rd_ptr   = 0;
        uflow    = 0;
        src_data = 32'hdead_beef;
        forever begin
            @(posedge clk);
            rd = fifo_rden;
            #1;
            if (rd) begin
                if (rd_ptr == wr_ptr) begin
                    uflow++;
                end else begin
                    src_data = src_mem[rd_ptr[7:0]];
                    rd_ptr++;
                end
            end
        end
    end

    int          n_vec = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wlog[$];
    int          wr_tot = 0;
    int          rd_tot = 0;
    int          done_tot = 0;
    logic [3:0]  dst_hist = 4'hf;
    bit          ovr_en = 0;
    logic [14:0] ovr_val = 15'd0;
    logic [31:0] next_val = 32'h11;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // One cycle: sample at the falling edge, check every write against the model.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        dst_hist = {dst_hist[2:0], fifo_dst_ready};
        if (nRST) begin
            if (fifo_wren) begin
                wr_tot++;
                wlog.push_back(fifo_wdata);
                if (exp_q.size() == 0) begin
                    check("extra_write", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("write_data", fifo_wdata, e);
                end
                check("write_without_dst_room", |dst_hist, 1'b1);
            end
            if (fifo_rden) rd_tot++;
            if (pack_done) begin
                done_tot++;
                check("done_before_last_write", exp_q.size(), 0);
            end
        end
        fifo_num_src = ovr_en ? ovr_val : 15'(wr_ptr - rd_ptr);
    endtask

    task automatic top_up(input int unsigned need);
        while ((wr_ptr - rd_ptr) < need) begin
            src_mem[wr_ptr[7:0]] = next_val;
            next_val++;
            wr_ptr++;
        end
    endtask

    // Expected write stream: the next flen source words, then pad up to slen.
    task automatic push_exp(input int unsigned flen, input int unsigned slen);
        logic [31:0] idx;
        for (int i = 0; i < int'(flen); i++) begin
            idx = rd_ptr + i;
            exp_q.push_back(src_mem[idx[7:0]]);
        end
        for (int i = int'(flen); i < int'(slen); i++) exp_q.push_back(PAD);
    endtask

    // mode 0: plain, 1: source stall, 2: dst toggling, 3: held request plus mid-job pulse
    task automatic run_job(input string name, input int unsigned flen, input int unsigned slen,
                           input int mode);
        int unsigned tot;
        int          wr0, rd0, dn0, t, first_rd, st, stall_bad;
        bit          done;
        tot = (flen > slen) ? flen : slen;
        top_up(flen + 20);
        fifo_num_src = 15'(wr_ptr - rd_ptr);
        exp_q.delete();
        wlog.delete();
        push_exp(flen, slen);
        wr0 = wr_tot;
        rd0 = rd_tot;
        dn0 = done_tot;
        frame_length = flen;
        sdram_length = slen;
        sdram_wr = 1'b1;
        t = 0;
        first_rd = -1;
        st = -1;
        stall_bad = 0;
        done = 0;
        while (!done && t < 400) begin
            tick();
            t++;
            if (first_rd < 0 && fifo_rden) first_rd = t;
            if (mode == 3) begin
                if (t == 50) sdram_wr = 1'b0;
                if (t == 55) sdram_wr = 1'b1;
                if (t == 57) check({name, "_busy_mid_pulse"}, busy, 1'b1);
                if (t == 58) sdram_wr = 1'b0;
            end else if (t == 2) begin
                sdram_wr = 1'b0;
            end
            if (mode == 1) begin
                if (st < 0 && (rd_tot - rd0) == 2) begin
                    ovr_en = 1;
                    ovr_val = 15'd10;
                    fifo_num_src = ovr_val;
                    st = 0;
                end else if (st >= 0 && st < 6) begin
                    st++;
                    if (st >= 2 && fifo_rden) stall_bad++;
                    if (st == 6) begin
                        ovr_val = 15'd11;
                        fifo_num_src = ovr_val;
                    end
                end
            end
            if (mode == 2) fifo_dst_ready = ((t / 3) % 2) == 0;
            if (done_tot != dn0) done = 1;
        end
        check({name, "_done_seen"}, done, 1'b1);
        sdram_wr = 1'b0;
        fifo_dst_ready = 1'b1;
        ovr_en = 0;
        repeat (8) tick();
        check({name, "_writes"}, wr_tot - wr0, tot);
        check({name, "_reads"}, rd_tot - rd0, flen);
        check({name, "_done_pulses"}, done_tot - dn0, 1);
        check({name, "_exp_drained"}, exp_q.size(), 0);
        check({name, "_idle_after"}, busy, 1'b0);
        if (mode == 0 && flen > 0) check({name, "_first_rden_latency"}, first_rd, 5);
        if (mode == 1) begin
            check({name, "_stall_engaged"}, st >= 0, 1'b1);
            check({name, "_reads_during_stall"}, stall_bad, 0);
        end
    endtask

    initial begin
        logic [31:0] lit [8];
        int          rd0, dn0, t;
        nRST = 1'b0;
        sdram_wr = 1'b0;
        frame_length = 0;
        sdram_length = 0;
        fifo_num_src = 0;
        fifo_dst_ready = 1'b1;
        repeat (3) tick();
        check("reset_rden", fifo_rden, 1'b0);
        check("reset_wren", fifo_wren, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", pack_done, 1'b0);
        nRST = 1'b1;
        repeat (3) tick();

        run_job("basic", 4, 8, 0);
        // Hand-computed stream for the first job
        lit = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h0, 32'h0, 32'h0, 32'h0};
        check("basic_log_len", wlog.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < wlog.size()) check("basic_literal_word", wlog[i], lit[i]);
        end

        run_job("stall", 4, 8, 1);
        run_job("pad_only", 0, 3, 0);
        run_job("zero_len", 0, 0, 0);
        run_job("no_pad", 6, 4, 0);
        run_job("dst_toggle", 4, 12, 2);
        run_job("hold", 20, 60, 3);

        // Reset in the middle of FRAME
        top_up(30);
        fifo_num_src = 15'(wr_ptr - rd_ptr);
        exp_q.delete();
        push_exp(10, 12);
        frame_length = 10;
        sdram_length = 12;
        rd0 = rd_tot;
        dn0 = done_tot;
        sdram_wr = 1'b1;
        t = 0;
        while ((rd_tot - rd0) < 3 && t < 50) begin
            tick();
            t++;
            if (t == 2) sdram_wr = 1'b0;
        end
        sdram_wr = 1'b0;
        check("rst_reached_frame", (rd_tot - rd0) >= 3, 1'b1);
        nRST = 1'b0;
        tick();
        check("rst_mid_rden", fifo_rden, 1'b0);
        check("rst_mid_wren", fifo_wren, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", pack_done, 1'b0);
        nRST = 1'b1;
        exp_q.delete();
        repeat (6) tick();
        check("rst_no_done_reported", done_tot - dn0, 0);
        check("rst_stays_idle", busy, 1'b0);
        run_job("after_reset", 5, 7, 0);

        check("source_underflow", uflow, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_frame_pack.md
# sdram_frame_pack

Write-side framer for the SDRAM path. On each start request it moves `frame_length` words from the capture (source) FIFO into the SDRAM write (destination) FIFO. It then appends `PAD_WORD` fill words until `sdram_length` words have been written. Every frame therefore lands in SDRAM as a fixed-size block, ready for the read-side formatter to strip the padding.

## Interface
- `DATA_W`, 32: data word width.
- `PAD_WORD`, 32'h0000_0000: fill value written during padding (`DATA_W` bits).
- `SRC_THRESH`, 15'd10: the source is treated as available only while `fifo_num_src` > `SRC_THRESH`.

- `clk`  in  1  system clock.
- `nRST`  in  1  reset; synchronous, active-low.
- `sdram_wr`  in  1  start request, asynchronous level; the rising edge is used.
- `frame_length`  in  32  payload words per frame; sampled at job start.
- `sdram_length`  in  32  total words per SDRAM block; sampled at job start.
- `fifo_num_src`  in  15  source FIFO fill count.
- `src_data`  in  `DATA_W`  source FIFO read data; valid the cycle after a read.
- `fifo_dst_ready`  in  1  destination FIFO can accept writes (high = room for at least 4 words).
- `fifo_rden`  out  1  source FIFO read enable.
- `fifo_wren`  out  1  destination FIFO write enable.
- `fifo_wdata`  out  `DATA_W`  destination FIFO write data.
- `busy`  out  1  job in progress (state is not IDLE).
- `pack_done`  out  1  one-cycle pulse at job end.

## Operation
- Reset values: `fifo_rden`=0, `fifo_wren`=0, `pack_done`=0, `busy`=0, all counters 0, state IDLE.
  - `fifo_wdata` is don't-care while `fifo_wren`=0.
- Input conditioning, all registered:
  - `sdram_wr` passes through a 3-flop chain (`wr0`, `wr1`, `wr2`); `start = wr1 & ~wr2`.
  - `src_ok <= (fifo_num_src > SRC_THRESH)`.
  - `dst_ok <= fifo_dst_ready`.
- At start: latch `flen = frame_length`, `slen = sdram_length`; `count` is 32-bit.
- States:
  - IDLE: `count`=0. On `start`, go to FRAME, or to PAD if `flen`=0.
  - FRAME: when `src_ok & dst_ok & count < flen`, issue a read: `fifo_rden`=1, `count`+1. Otherwise `fifo_rden`=0. When `count == flen`, go to PAD.
  - PAD: when `dst_ok & count < slen`, issue a pad request, `count`+1. When `count >= slen`, go to DONE.
    - If `flen >= slen`, PAD issues nothing and passes straight through to DONE.
  - DONE: outstanding write completes; go to IDLE next cycle.
- Write stage, one-cycle pipeline behind issue:
  - `fifo_wren <= fifo_rden | pad_req`.
  - `sel_pad <= pad_req`.
  - `fifo_wdata = sel_pad ? PAD_WORD : src_data` (combinational mux from the registered select).
- Words written per job = `max(flen, slen)`; reads per job = `flen`.
- `pack_done`: high exactly one cycle, the cycle after the final `fifo_wren`. For a zero-word job (`flen = slen = 0`) it is high the cycle after IDLE is left.
- A `start` arriving while `busy` is ignored and not queued. A held-high `sdram_wr` yields exactly one job.
- `nRST` low at any edge: return to reset values at that edge. An in-flight word may be dropped; no completion is reported.

## Timing
- `sdram_wr` first sampled high at edge k gives `start`=1 after edge k+2. The state leaves IDLE at edge k+3, and the earliest `fifo_rden` is high after edge k+4.
- Read-to-write latency is 1 cycle; sustained throughput is 1 word/clk while `src_ok & dst_ok`.
- `src_ok` and `dst_ok` lag their inputs by 1 cycle; `SRC_THRESH` and the 4-word destination margin absorb the lag. Neither FIFO may underflow or overflow.
- Counter compares are unsigned 32-bit; `count` never wraps because it stops at `max(flen, slen)`.

## Test plan
- `frame_length`=4, `sdram_length`=8, source preloaded 0x11..0x14 plus 20 extra words, dst ready → 4 `fifo_rden`, 8 `fifo_wren`, data 0x11,0x12,0x13,0x14 then 4× `PAD_WORD`, one `pack_done`.
- Same job with `fifo_num_src` dropping to 10 after 2 reads → reads stall within 2 cycles, resume when the count rises to 11, output sequence unchanged.
- `frame_length`=0, `sdram_length`=3 → zero reads, 3 `PAD_WORD` writes, `pack_done`.
- `frame_length`=6, `sdram_length`=4 → 6 reads, 6 writes, no pad.
- `fifo_dst_ready` toggling 1/0 every 3 cycles during PAD → `fifo_wren` only while `dst_ok`, total writes exact.
- `sdram_wr` held high for 50 cycles, plus a second pulse mid-job → exactly one job.
- `nRST` low during FRAME → next edge: all outputs 0, IDLE; a new start runs a full job.
